// File: rtl/prog_loader.sv
// Byte-stream program loader: length + data + XOR checksum frame into the 16x8 instruction memory.
// Memory writes are registered, one cycle after each data-byte acceptance.
// data_ready is decoded from state only, so a low data_valid stalls with no side effects.
module prog_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_req,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       mem_we,
    output logic [3:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] len_q, len_d;
    logic [7:0] csum_q, csum_d;
    logic       pvalid_q, pvalid_d;
    logic       done_q, done_d;
    logic [1:0] err_q, err_d;
    logic       we_q, we_d;
    logic [3:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;

    logic in_frame;
    logic accept;

    assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    // A dropped load_req wins over a byte offered in the same cycle.
    assign accept   = in_frame && data_valid && load_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        csum_d   = csum_q;
        pvalid_d = pvalid_q;
        done_d   = done_q;
        err_d    = err_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (in_frame && !load_req) begin
            err_d   = ERR_ABORT;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_req) begin
                        state_d  = S_LEN;
                        pvalid_d = 1'b0;
                        done_d   = 1'b0;
                        err_d    = ERR_NONE;
                        csum_d   = 8'h00;
                        cnt_d    = 5'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        csum_d = data_in;
                        if (data_in >= 8'h01 && data_in <= 8'h10) begin
                            len_d   = data_in[4:0];
                            state_d = S_DATA;
                        end else begin
                            err_d   = ERR_LEN;
                            state_d = S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum_d  = csum_q ^ data_in;
                        we_d    = 1'b1;
                        waddr_d = cnt_q[3:0];
                        wdata_d = data_in;
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q + 5'd1 == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (data_in == csum_q) begin
                            pvalid_d = 1'b1;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            err_d   = ERR_CSUM;
                            state_d = S_ERR;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (!load_req) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            len_q    <= 5'd0;
            csum_q   <= 8'h00;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            we_q     <= 1'b0;
            waddr_q  <= 4'd0;
            wdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            csum_q   <= csum_d;
            pvalid_q <= pvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign data_ready = in_frame;
    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = !pvalid_q;
    assign done       = done_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good frame, checksum/length errors, full depth with stalls, abort, reset.
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then inspected 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        step();
        data_valid = 1'b0;
    endtask

    task automatic restart();
        load_req = 1'b0;
        step();
        load_req = 1'b1;
        step();
    endtask

    logic [7:0] xs;
    logic [7:0] d;

    initial begin
        rst_n      = 1'b0;
        load_req   = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        #12;
        chk("rst_ready", data_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err_code, 0);
        rst_n = 1'b1;
        step();

        // Good frame 03 12 34 56 73
        chk("idle_ready", data_ready, 0);
        load_req = 1'b1;
        step();
        chk("len_ready", data_ready, 1);
        send(8'h03);
        chk("g_len_we", mem_we, 0);
        send(8'h12);
        chk("g_we0", mem_we, 1);
        chk("g_a0", mem_waddr, 0);
        chk("g_d0", mem_wdata, 8'h12);
        send(8'h34);
        chk("g_we1", mem_we, 1);
        chk("g_a1", mem_waddr, 1);
        chk("g_d1", mem_wdata, 8'h34);
        send(8'h56);
        chk("g_we2", mem_we, 1);
        chk("g_a2", mem_waddr, 2);
        chk("g_d2", mem_wdata, 8'h56);
        chk("g_hold_pre", cpu_hold, 1);
        send(8'h73);
        chk("g_we_ck", mem_we, 0);
        chk("g_done", done, 1);
        chk("g_err", err_code, 0);
        chk("g_hold", cpu_hold, 0);
        chk("g_ready", data_ready, 0);
        load_req = 1'b0;
        step();
        chk("g_idle_done", done, 1);
        chk("g_idle_hold", cpu_hold, 0);

        // Checksum mismatch
        load_req = 1'b1;
        step();
        chk("c_len_done", done, 0);
        chk("c_len_hold", cpu_hold, 1);
        send(8'h03); send(8'h12); send(8'h34); send(8'h56);
        send(8'h72);
        chk("c_err", err_code, 2);
        chk("c_done", done, 0);
        chk("c_hold", cpu_hold, 1);
        chk("c_ready", data_ready, 0);
        data_valid = 1'b1;
        data_in    = 8'h03;
        step(); step();
        chk("c_stuck_ready", data_ready, 0);
        chk("c_stuck_we", mem_we, 0);
        chk("c_stuck_err", err_code, 2);
        data_valid = 1'b0;
        load_req = 1'b0;
        step();
        chk("c_idle_err", err_code, 2);
        load_req = 1'b1;
        step();
        chk("c_relen_err", err_code, 0);
        chk("c_relen_ready", data_ready, 1);

        // Bad lengths
        send(8'h00);
        chk("l0_err", err_code, 1);
        chk("l0_we", mem_we, 0);
        chk("l0_ready", data_ready, 0);
        restart();
        send(8'h11);
        chk("l11_err", err_code, 1);
        chk("l11_we", mem_we, 0);

        // Full depth with stalls
        restart();
        send(8'h10);
        xs = 8'h10;
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                step();
                chk("f_gap_we", mem_we, 0);
            end
            d  = 8'(i * 13 + 7);
            xs = xs ^ d;
            send(d);
            chk("f_we", mem_we, 1);
            chk("f_addr", mem_waddr, i);
            chk("f_data", mem_wdata, d);
        end
        chk("f_hold_pre", cpu_hold, 1);
        step();
        chk("f_stall_done", done, 0);
        send(xs);
        chk("f_done", done, 1);
        chk("f_err", err_code, 0);
        chk("f_hold", cpu_hold, 0);
        chk("f_we_ck", mem_we, 0);

        // Abort after 2 of 4 data bytes
        restart();
        send(8'h04); send(8'hAA); send(8'hBB);
        load_req   = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'hCC;
        step();
        data_valid = 1'b0;
        chk("a_err", err_code, 3);
        chk("a_ready", data_ready, 0);
        chk("a_we", mem_we, 0);
        chk("a_hold", cpu_hold, 1);
        chk("a_done", done, 0);
        load_req = 1'b1;
        step();
        chk("a2_err", err_code, 0);
        send(8'h02); send(8'h5A); send(8'hA5);
        send(8'hFD);
        chk("a2_done", done, 1);
        chk("a2_err_end", err_code, 0);
        chk("a2_hold", cpu_hold, 0);

        // Asynchronous reset mid-DATA
        restart();
        send(8'h03);
        send(8'h11);
        chk("r_we_pre", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_ready", data_ready, 0);
        chk("r_we", mem_we, 0);
        chk("r_waddr", mem_waddr, 0);
        chk("r_wdata", mem_wdata, 0);
        chk("r_hold", cpu_hold, 1);
        chk("r_done", done, 0);
        chk("r_err", err_code, 0);
        load_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("r_idle_ready", data_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the processor's 16 x 8 instruction memory before execution starts. It accepts a framed stream of a length byte, instruction bytes, and an XOR checksum over a valid/ready byte handshake, driven from the top-level 8-bit input. It issues one write per instruction byte into the instruction memory and holds the processor in reset until a frame passes its checksum. It is the writer for the instruction store that the CPU fetch path reads.

## Interface
- No parameters. Memory depth is fixed at 16 words (4-bit address) and word width at 8 bits.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_req  input  1  level; high requests or continues a load session.
- data_in  input  8  stream byte; sampled on acceptance.
- data_valid  input  1  byte on data_in is valid.
- data_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_waddr  output  4  write address.
- mem_wdata  output  8  write data.
- cpu_hold  output  1  high keeps the processor in reset.
- done  output  1  last load succeeded (sticky).
- err_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 abort.

## Operation
- Acceptance occurs when data_valid and data_ready are both high on a rising clk edge.
- States and transitions:
  - IDLE: data_ready=0. Goes to LEN when load_req=1. On that transition: program_valid=0, done=0, err_code=00, checksum=0, word counter=0.
  - LEN: data_ready=1. Accepted byte L sets checksum=L.
    - If L is 0x01..0x10: store count=L and go to DATA.
    - Otherwise: err_code=01, go to ERR.
  - DATA: data_ready=1. Each accepted byte B:
    - checksum ^= B.
    - Registered write: mem_waddr=counter, mem_wdata=B, mem_we=1 for one cycle.
    - counter increments.
    - After the L-th byte, go to CHECK.
  - CHECK: data_ready=1. Accepted byte C:
    - If C equals checksum: program_valid=1, done=1, go to DONE.
    - Otherwise: err_code=10, go to ERR.
  - DONE and ERR: data_ready=0. Stay while load_req=1. Go to IDLE when load_req=0.
- Abort: load_req=0 while in LEN, DATA or CHECK sets err_code=11, program_valid stays 0, next state is IDLE. A byte presented in that same cycle is not accepted.
- cpu_hold = !program_valid.
- Memory words already written by a failed or aborted frame stay in memory, but the CPU remains held.
- Status persistence: done and err_code hold their values through IDLE until the next LEN entry.
- Width rules:
  - Counter is 5 bits internally, and mem_waddr = counter[3:0].
  - A 16-word frame writes addresses 0..15; there is no wrap beyond word 15.
  - Checksum is the 8-bit XOR of the length byte and every data byte.

## Timing
- Reset values (asynchronous): state=IDLE, data_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, err_code=00, counter=0, checksum=0.
- Reset asserted mid-frame returns the block to IDLE immediately, with cpu_hold=1.
- data_ready is decoded from the registered state only; there is no combinational path from data_valid.
- mem_we/mem_waddr/mem_wdata are registered outputs, valid exactly one cycle after the acceptance edge. mem_we is never high for two cycles for the same byte.
- Back-to-back acceptance is supported: one byte per cycle, giving consecutive mem_we pulses.
- Latency:
  - A full L-word frame with data_valid held high takes L+2 accepting cycles.
  - done and cpu_hold=0 are visible on the cycle after the checksum byte is accepted.
  - The first cycle of data_ready=1 in LEN is the cycle after load_req is sampled high in IDLE.
- data_valid low stalls any state with no side effects.

## Test plan
- Reset: assert rst_n=0 mid-DATA → all outputs at their reset values within the same cycle; cpu_hold=1.
- Good frame: load_req=1, bytes 0x03,0x12,0x34,0x56,0x73 with continuous valid →
  - mem_we pulses at addresses 0,1,2 with data 0x12,0x34,0x56;
  - done=1, err_code=00, cpu_hold=0 one cycle after 0x73 is accepted.
- Checksum error: the same frame with a final byte of 0x72 → err_code=10, done=0, cpu_hold=1; data_ready=0 until load_req drops and is reasserted.
- Bad length: bytes 0x00, then a new session with 0x11 → err_code=01 each time, no mem_we.
- Full depth and stalls: length 0x10, 16 bytes with random data_valid gaps, correct XOR → addresses 0..15 each written exactly once, done=1.
- Abort: drop load_req after 2 of 4 data bytes → err_code=11, IDLE next cycle, cpu_hold stays 1; a subsequent good frame clears err_code and succeeds.
